// File: rtl/pll_reconfig_pkg.sv
// Shared register map, command kinds and sequencer states for the PLL reconfiguration master.
package pll_reconfig_pkg;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    localparam logic [AW-1:0] ADDR_MODE   = 6'h00;
    localparam logic [AW-1:0] ADDR_STATUS = 6'h01;
    localparam logic [AW-1:0] ADDR_START  = 6'h02;
    localparam logic [AW-1:0] ADDR_N      = 6'h03;
    localparam logic [AW-1:0] ADDR_M      = 6'h04;
    localparam logic [AW-1:0] ADDR_C      = 6'h05;
    localparam logic [AW-1:0] ADDR_DPS    = 6'h06;

    typedef enum logic [1:0] {
        KIND_C   = 2'd0,
        KIND_DPS = 2'd1,
        KIND_M   = 2'd2,
        KIND_N   = 2'd3
    } cmd_kind_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_REG,
        S_WR_START,
        S_GAP,
        S_RD_STATUS,
        S_LOCK,
        S_FIN,
        S_ERR
    } state_e;

    function automatic logic [AW-1:0] kind_to_addr(input cmd_kind_e kind);
        logic [AW-1:0] a;
        case (kind)
            KIND_C:   a = ADDR_C;
            KIND_DPS: a = ADDR_DPS;
            KIND_M:   a = ADDR_M;
            KIND_N:   a = ADDR_N;
            default:  a = ADDR_C;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/avm_single_xfer.sv
// Single Avalon-MM transfer: strobe one cycle after start_i, held until waitrequest drops.
// done_o pulses the cycle after completion (bus idle that cycle), with captured readdata in rdata_o.
module avm_single_xfer
    import pll_reconfig_pkg::*;
(
    input  logic          clk,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          wr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          done_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] avm_address_o,
    output logic          avm_read_o,
    output logic          avm_write_o,
    output logic [DW-1:0] avm_writedata_o,
    input  logic [DW-1:0] avm_readdata_i,
    input  logic          avm_waitrequest_i
);

    logic          read_q, read_d;
    logic          write_q, write_d;
    logic          done_q, done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          active;
    logic          complete;

    assign active   = read_q | write_q;
    assign complete = active & ~avm_waitrequest_i;

    always_comb begin
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = complete;
        if (complete) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            if (read_q) rdata_d = avm_readdata_i;
        end else if (start_i && !active) begin
            read_d  = ~wr_i;
            write_d = wr_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            read_q  <= read_d;
            write_q <= write_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign done_o          = done_q;
    assign rdata_o         = rdata_q;
    assign avm_address_o   = addr_q;
    assign avm_read_o      = read_q;
    assign avm_write_o     = write_q;
    assign avm_writedata_o = wdata_q;

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Runs one PLL reconfig command (mode, target, start, status poll, optional lock wait) over Avalon-MM.
// One command at a time: cmd_ready only in IDLE; done/err pulse then IDLE; timeout never cuts a transfer.
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned POLL_GAP       = 4,
    parameter bit          WAIT_LOCK      = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_kind,
    input  logic [DW-1:0] cmd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] avm_address,
    output logic          avm_read,
    output logic          avm_write,
    output logic [DW-1:0] avm_writedata,
    input  logic [DW-1:0] avm_readdata,
    input  logic          avm_waitrequest,
    input  logic          pll_locked
);

    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned   GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    state_e        state_q, state_d;
    cmd_kind_e     kind_q, kind_d;
    logic [DW-1:0] data_q, data_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          issued_q, issued_d;
    logic          lock_s1_q, lock_s2_q;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept, in_seq, to_hit, abort;
    logic          xfer_state, xfer_start, xfer_wr, xfer_done;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_wdata, xfer_rdata;
    logic          unused_rdata;

    assign accept  = (state_q == S_IDLE) & cmd_valid;
    assign in_seq  = state_q inside {S_WR_MODE, S_WR_REG, S_WR_START, S_GAP, S_RD_STATUS, S_LOCK};
    assign to_hit  = (to_cnt_q == TO_MAX);
    // issued_q spans start..done of a transfer, so abort waits for the bus to go quiet
    assign abort   = in_seq & to_hit & ~issued_q;
    assign unused_rdata = ^xfer_rdata[DW-1:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kind_q      <= KIND_C;
            data_q      <= '0;
            to_cnt_q    <= '0;
            gap_q       <= '0;
            issued_q    <= 1'b0;
            lock_s1_q   <= 1'b0;
            lock_s2_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            data_q      <= data_d;
            to_cnt_q    <= to_cnt_d;
            gap_q       <= gap_d;
            issued_q    <= issued_d;
            lock_s1_q   <= pll_locked;
            lock_s2_q   <= lock_s1_q;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_ERR;
        end else begin
            case (state_q)
                S_IDLE:      if (cmd_valid) state_d = S_WR_MODE;
                S_WR_MODE:   if (xfer_done) state_d = S_WR_REG;
                S_WR_REG:    if (xfer_done) state_d = S_WR_START;
                S_WR_START:  if (xfer_done) state_d = S_GAP;
                S_GAP:       if (gap_q == GAP_LAST) state_d = S_RD_STATUS;
                S_RD_STATUS: begin
                    if (xfer_done) begin
                        if (!xfer_rdata[0]) state_d = S_GAP;
                        else if (WAIT_LOCK) state_d = S_LOCK;
                        else                state_d = S_FIN;
                    end
                end
                S_LOCK:      if (lock_s2_q) state_d = S_FIN;
                S_FIN:       state_d = S_IDLE;
                S_ERR:       state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        xfer_wr    = 1'b1;
        xfer_addr  = ADDR_MODE;
        xfer_wdata = '0;
        case (state_q)
            S_WR_MODE:   xfer_wdata = 32'd1;
            S_WR_REG: begin
                xfer_addr  = kind_to_addr(kind_q);
                xfer_wdata = data_q;
            end
            S_WR_START:  xfer_addr = ADDR_START;
            S_RD_STATUS: begin
                xfer_wr   = 1'b0;
                xfer_addr = ADDR_STATUS;
            end
            default: ;
        endcase
        xfer_state  = state_q inside {S_WR_MODE, S_WR_REG, S_WR_START, S_RD_STATUS};
        xfer_start  = xfer_state & ~issued_q & ~abort;
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = !(state_d inside {S_IDLE, S_FIN, S_ERR});
        done_d      = (state_d == S_FIN);
        err_d       = (state_d == S_ERR);
    end

    always_comb begin
        kind_d   = kind_q;
        data_d   = data_q;
        to_cnt_d = to_cnt_q;
        if (accept) begin
            kind_d   = cmd_kind_e'(cmd_kind);
            data_d   = cmd_data;
            to_cnt_d = '0;
        end else if (in_seq && !to_hit) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        gap_d = (state_q == S_GAP) ? gap_q + GW'(1) : '0;
        if (xfer_done)       issued_d = 1'b0;
        else if (xfer_start) issued_d = 1'b1;
        else                 issued_d = issued_q;
    end

    avm_single_xfer u_xfer (
        .clk               (clk),
        .rst_i             (reset),
        .start_i           (xfer_start),
        .wr_i              (xfer_wr),
        .addr_i            (xfer_addr),
        .wdata_i           (xfer_wdata),
        .done_o            (xfer_done),
        .rdata_o           (xfer_rdata),
        .avm_address_o     (avm_address),
        .avm_read_o        (avm_read),
        .avm_write_o       (avm_write),
        .avm_writedata_o   (avm_writedata),
        .avm_readdata_i    (avm_readdata),
        .avm_waitrequest_i (avm_waitrequest)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench: Avalon slave model with configurable stall/status/lock, vector table plus corner sequences.
module tb_pll_reconfig_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [31:0] cmd_data;
    logic        busy, done, err;
    logic [5:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'hFFFF_FFFF;
    logic        avm_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;

    pll_reconfig_sequencer #(
        .TIMEOUT_CYCLES (200),
        .POLL_GAP       (4),
        .WAIT_LOCK      (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_kind        (cmd_kind),
        .cmd_data        (cmd_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .pll_locked      (pll_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [5:0]  addr;
        int          stall;
        int          zeros;
        int          lock_dly;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        int          hold;
    } xfer_t;

    xfer_t xlog[$];
    vec_t  vecs[5];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_cfg = 0, zeros_cfg = 0, lock_dly_cfg = 0;
    int wait_cnt = 0, hold = 0, st_rd_cnt = 0, lock_raise = 0;
    int unstable_n = 0, b2b_n = 0;
    logic prev_cmpl = 1'b0;
    logic [5:0]  cur_addr = '0;
    logic [31:0] cur_wd = '0;
    logic        cur_wr = 1'b0;
    int done_n = 0, err_n = 0, both_n = 0, ready_n = 0, done_cyc = 0, err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon slave model: stall_cfg wait cycles per transfer, status reads 0 for zeros_cfg reads then 1
    always @(negedge clk) begin
        logic st;
        pll_locked = (cyc >= lock_raise);
        if (reset) begin
            wait_cnt = 0; hold = 0; prev_cmpl = 1'b0;
            avm_waitrequest = 1'b0; avm_readdata = 32'hFFFF_FFFF;
        end else if (avm_read || avm_write) begin
            if (hold == 0) begin
                if (prev_cmpl) b2b_n++;
                cur_addr = avm_address; cur_wd = avm_writedata; cur_wr = avm_write;
            end else if (avm_address !== cur_addr || avm_writedata !== cur_wd ||
                         avm_write !== cur_wr || avm_read !== !cur_wr) begin
                unstable_n++;
            end
            hold++;
            prev_cmpl = 1'b0;
            if (wait_cnt < stall_cfg) begin
                wait_cnt++;
                avm_waitrequest = 1'b1;
                avm_readdata = 32'hFFFF_FFFF;
            end else begin
                avm_waitrequest = 1'b0;
                wait_cnt = 0;
                prev_cmpl = 1'b1;
                xlog.push_back('{cur_wr, cur_addr, cur_wr ? cur_wd : 32'h0, hold});
                hold = 0;
                if (cur_wr && cur_addr == 6'h00) begin
                    st_rd_cnt = 0;
                    lock_raise = (lock_dly_cfg > 0) ? 2147483647 : 0;
                end
                if (!cur_wr) begin
                    st = (st_rd_cnt >= zeros_cfg);
                    st_rd_cnt++;
                    avm_readdata = {31'h2D2D_5A5A, st};
                    if (st && lock_dly_cfg > 0) lock_raise = cyc + lock_dly_cfg;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
            avm_readdata = 32'hFFFF_FFFF;
            prev_cmpl = 1'b0; hold = 0; wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin done_n++; done_cyc = cyc; end
            if (err)  begin err_n++;  err_cyc = cyc;  end
            if (done && err) both_n++;
            if (cmd_ready) ready_n++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] k, input logic [31:0] d, output int acc);
        int n = 0;
        while (!cmd_ready && n < 500) begin tick(); n++; end
        chk("issue_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_kind = k; cmd_data = d;
        tick();
        acc = cyc;
        cmd_valid = 1'b0; cmd_kind = ~k; cmd_data = ~d;
    endtask

    task automatic wait_end(input int d0, input int e0, input int bound, input string name);
        int n = 0;
        while (done_n == d0 && err_n == e0 && n < bound) begin tick(); n++; end
        chk({name, " finished"}, 64'(done_n != d0 || err_n != e0), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int base, d0, e0, acc, nexp;
        logic [5:0] ea;
        logic [31:0] ed;
        logic ew;
        stall_cfg = v.stall; zeros_cfg = v.zeros; lock_dly_cfg = v.lock_dly;
        base = xlog.size(); d0 = done_n; e0 = err_n;
        issue(v.kind, v.data, acc);
        chk({name, " busy"}, 64'(busy), 64'd1);
        wait_end(d0, e0, 600, name);
        chk({name, " done/busy"}, 64'({done, busy}), 64'b10);
        tick(); tick();
        chk({name, " done_cnt"}, 64'(done_n - d0), 64'd1);
        chk({name, " err_cnt"}, 64'(err_n - e0), 64'd0);
        nexp = 4 + v.zeros;
        chk({name, " xfer_cnt"}, 64'(xlog.size() - base), 64'(nexp));
        for (int i = 0; i < nexp && base + i < xlog.size(); i++) begin
            case (i)
                0:       begin ew = 1'b1; ea = 6'h00;  ed = 32'd1;  end
                1:       begin ew = 1'b1; ea = v.addr; ed = v.data; end
                2:       begin ew = 1'b1; ea = 6'h02;  ed = 32'd0;  end
                default: begin ew = 1'b0; ea = 6'h01;  ed = 32'd0;  end
            endcase
            chk($sformatf("%s xfer%0d", name, i),
                64'({xlog[base+i].wr, xlog[base+i].addr, xlog[base+i].data}), 64'({ew, ea, ed}));
            chk($sformatf("%s hold%0d", name, i), 64'(xlog[base+i].hold), 64'(v.stall + 1));
        end
        if (v.lock_dly > 0)
            chk({name, " lock_wait"},
                64'(done_cyc >= lock_raise + 3 && done_cyc <= lock_raise + 4), 64'd1);
        chk({name, " idle_after"}, 64'({cmd_ready, busy}), 64'b10);
    endtask

    initial begin
        int acc, d0, e0, n, base, r0, r1;
        logic [5:0]  ca[8];
        logic [31:0] cd[8];
        logic        cw[8];

        vecs[0] = '{2'd0, 32'h0002_0404, 6'h05, 0, 2, 0};
        vecs[1] = '{2'd0, 32'h1234_5678, 6'h05, 3, 1, 0};
        vecs[2] = '{2'd1, 32'h0021_0005, 6'h06, 0, 0, 20};
        vecs[3] = '{2'd2, 32'h0000_0808, 6'h04, 1, 0, 0};
        vecs[4] = '{2'd3, 32'h0000_0101, 6'h03, 0, 1, 0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_data = 32'h0;
        repeat (3) tick();
        chk("reset_state",
            64'({cmd_ready, busy, done, err, avm_read, avm_write, avm_address, avm_writedata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0}));
        reset = 1'b0;
        tick(); tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // status stuck at 0: abort after ~200 busy cycles
        stall_cfg = 0; zeros_cfg = 1000000; lock_dly_cfg = 0;
        d0 = done_n; e0 = err_n;
        issue(2'd0, 32'hAAAA_0001, acc);
        wait_end(d0, e0, 400, "timeout");
        chk("to_err_state", 64'({err, cmd_ready, busy}), 64'b100);
        tick();
        chk("to_ready_after", 64'({err, cmd_ready}), 64'b01);
        chk("to_err_cnt", 64'(err_n - e0), 64'd1);
        chk("to_done_cnt", 64'(done_n - d0), 64'd0);
        chk("to_window", 64'(err_cyc >= acc + 200 && err_cyc <= acc + 210), 64'd1);
        run_vec(vecs[0], "after_to");

        // reset while the target-register write is stalled on the bus
        stall_cfg = 10; zeros_cfg = 0; lock_dly_cfg = 0;
        issue(2'd1, 32'h1357_9BDF, acc);
        n = 0;
        while (!(avm_write && avm_address == 6'h06) && n < 200) begin tick(); n++; end
        chk("rst_reach_wr_reg", 64'(avm_write && avm_address == 6'h06), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_async",
            64'({cmd_ready, busy, done, err, avm_read, avm_write, avm_address, avm_writedata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0}));
        tick(); tick();
        reset = 1'b0;
        tick();
        run_vec(vecs[3], "after_rst");

        // cmd_valid held across two commands
        stall_cfg = 0; zeros_cfg = 0; lock_dly_cfg = 0;
        base = xlog.size(); d0 = done_n;
        cmd_valid = 1'b1; cmd_kind = 2'd2; cmd_data = 32'h0000_0808;
        n = 0;
        while (done_n == d0 && n < 300) begin tick(); n++; end
        r0 = ready_n;
        cmd_kind = 2'd3; cmd_data = 32'h0000_0101;
        n = 0;
        while (done_n < d0 + 2 && n < 300) begin tick(); n++; end
        cmd_valid = 1'b0;
        r1 = ready_n;
        tick(); tick();
        chk("cont_done_cnt", 64'(done_n - d0), 64'd2);
        chk("cont_idle_gap", 64'(r1 - r0 >= 1), 64'd1);
        chk("cont_xfer_cnt", 64'(xlog.size() - base), 64'd8);
        ca = '{6'h00, 6'h04, 6'h02, 6'h01, 6'h00, 6'h03, 6'h02, 6'h01};
        cd = '{32'd1, 32'h0808, 32'd0, 32'd0, 32'd1, 32'h0101, 32'd0, 32'd0};
        cw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8 && base + i < xlog.size(); i++)
            chk($sformatf("cont xfer%0d", i),
                64'({xlog[base+i].wr, xlog[base+i].addr, xlog[base+i].data}),
                64'({cw[i], ca[i], cd[i]}));

        chk("bus_hold_stable", 64'(unstable_n), 64'd0);
        chk("no_back_to_back", 64'(b2b_n), 64'd0);
        chk("done_err_overlap", 64'(both_n), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
